vector_lsu: RTL

Vector load/store unit. Sits directly downstream of `vector_decoder`, consuming its `vlsu_en/load/store/strided` controls plus scalar base address and stride. It moves 8-bit elements between data memory (OBI-style request/grant/rvalid port shared with the core's LSU arbiter) and the 32-bit-per-register vector register file. Unit-stride accesses move whole words; strided accesses move single bytes and pack or unpack them into register words.

---
 rtl/accelerator_pkg.sv | 34 +++
 rtl/vlsu_addr_gen.sv | 55 +++++
 rtl/vector_lsu.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/accelerator_pkg.sv
// Shared types and helpers for the vector accelerator blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package accelerator_pkg;

   // Bytes (elements) carried by one vector register word / memory word.
   localparam int VLSU_ELEM_BYTES = 4;

   typedef enum logic [1:0] {
      VLSU_IDLE = 2'd0,
      VLSU_REQ  = 2'd1,
      VLSU_RESP = 2'd2,
      VLSU_DONE = 2'd3
   } vlsu_state_t;

   // Element enable mask for a word given the number of elements still to move.
   function automatic logic [3:0] vlsu_elem_mask(input logic [6:0] remaining);
      logic [3:0] mask;
      case (remaining)
         7'd0:    mask = 4'b0000;
         7'd1:    mask = 4'b0001;
         7'd2:    mask = 4'b0011;
         7'd3:    mask = 4'b0111;
         default: mask = 4'b1111;
      endcase
      return mask;
   endfunction

   // Byte-enable for a single-byte access in the given lane.
   function automatic logic [3:0] vlsu_onehot(input logic [1:0] lane);
      return 4'b0001 << lane;
   endfunction

endpackage

// File: rtl/vlsu_addr_gen.sv
// Address sequencer for vector memory accesses: base/stride accumulator and element/word counter.
// Latency: address for transfer n is valid the cycle after start (n=0) or after advance.
// Backpressure: holds the current address until advance is asserted.
module vlsu_addr_gen
   import accelerator_pkg::*;
(
   input  logic        clk,
   input  logic        n_reset,
   input  logic        start,
   input  logic        advance,
   input  logic [31:0] base_addr,
   input  logic [31:0] stride,
   input  logic        strided,
   input  logic [4:0]  vl,
   output logic [31:0] addr,
   output logic [4:0]  idx,
   output logic [1:0]  lane,
   output logic [1:0]  offset,
   output logic        last,
   output logic [4:0]  vl_q,
   output logic        strided_q
);

   logic [31:0] step_q;
   logic [4:0]  words;

   // Latch access geometry on start, then step the address once per completed transfer.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         addr      <= '0;
         idx       <= '0;
         step_q    <= '0;
         vl_q      <= '0;
         strided_q <= 1'b0;
      end else if (start) begin
         addr      <= base_addr;
         idx       <= '0;
         step_q    <= strided ? stride : 32'(VLSU_ELEM_BYTES);
         vl_q      <= vl;
         strided_q <= strided;
      end else if (advance) begin
         addr <= addr + step_q;
         idx  <= idx + 5'd1;
      end
   end

   // Unit-stride counts words, strided counts single elements.
   always_comb begin
      words  = (vl_q + 5'd3) >> 2;
      lane   = addr[1:0];
      offset = strided_q ? idx[3:2] : idx[1:0];
      last   = strided_q ? (idx == vl_q - 5'd1) : (idx == words - 5'd1);
   end

endmodule

// File: rtl/vector_lsu.sv
// Vector load/store unit: moves 8-bit elements between OBI data memory and the vector register file.
// Latency: request the cycle after acceptance; 2 cycles per transfer with zero-wait memory, plus one DONE cycle.
// Backpressure: request held stable until grant; one outstanding transaction; start ignored unless idle.
module vector_lsu
   import accelerator_pkg::*;
#(
   parameter int MAX_VL = 16
)(
   input  logic        clk,
   input  logic        n_reset,
   input  logic        vlsu_en_i,
   input  logic        vlsu_load_i,
   input  logic        vlsu_store_i,
   input  logic        vlsu_strided_i,
   input  logic [31:0] base_addr_i,
   input  logic [31:0] stride_i,
   input  logic [4:0]  vl_i,
   output logic        vlsu_ready_o,
   output logic        vlsu_done_o,
   output logic        vlsu_error_o,
   output logic        data_req_o,
   input  logic        data_gnt_i,
   output logic [31:0] data_addr_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_rvalid_i,
   input  logic [31:0] data_rdata_i,
   output logic [1:0]  vr_offset_o,
   output logic [31:0] vr_wdata_o,
   output logic [3:0]  vr_wbe_o,
   output logic        vr_we_o,
   input  logic [31:0] vr_rdata_i
);

   vlsu_state_t state_q, state_d;
   logic        is_load_q;
   logic        error_q;
   logic [31:0] pack_q;
   logic [31:0] pack_nxt;

   logic        accept;
   logic        bad_align;
   logic        advance;
   logic [4:0]  vl_clamped;

   logic [31:0] cur_addr;
   logic [4:0]  idx;
   logic [1:0]  lane;
   logic [1:0]  offset;
   logic        last;
   logic [4:0]  ag_vl;
   logic        ag_strided;

   logic [1:0]  elem;
   logic [6:0]  remaining;
   logic [3:0]  unit_mask;
   logic [3:0]  packed_mask;
   logic [7:0]  rd_byte;
   logic [7:0]  st_byte;

   assign accept     = (state_q == VLSU_IDLE) && vlsu_en_i && (vlsu_load_i ^ vlsu_store_i);
   assign vl_clamped = (int'(vl_i) > MAX_VL) ? 5'(MAX_VL) : vl_i;
   assign bad_align  = !vlsu_strided_i && (base_addr_i[1:0] != 2'b00);
   assign advance    = (state_q == VLSU_RESP) && data_rvalid_i;

   vlsu_addr_gen u_addr_gen (
      .clk       (clk),
      .n_reset   (n_reset),
      .start     (accept),
      .advance   (advance),
      .base_addr (base_addr_i),
      .stride    (stride_i),
      .strided   (vlsu_strided_i),
      .vl        (vl_clamped),
      .addr      (cur_addr),
      .idx       (idx),
      .lane      (lane),
      .offset    (offset),
      .last      (last),
      .vl_q      (ag_vl),
      .strided_q (ag_strided)
   );

   // Element position and masks for the current transfer.
   always_comb begin
      elem        = idx[1:0];
      remaining   = 7'(ag_vl) - {idx, 2'b00};
      unit_mask   = vlsu_elem_mask(remaining);
      packed_mask = 4'((5'd2 << elem) - 5'd1);
      rd_byte     = data_rdata_i[{lane, 3'b000} +: 8];
      st_byte     = vr_rdata_i[{elem, 3'b000} +: 8];
   end

   // State register.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) state_q <= VLSU_IDLE;
      else          state_q <= state_d;
   end

   // Next-state: vl==0 completes with no traffic, misaligned unit-stride is rejected in IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         VLSU_IDLE: begin
            if (accept) begin
               if (vl_clamped == 5'd0) state_d = VLSU_DONE;
               else if (!bad_align)    state_d = VLSU_REQ;
            end
         end
         VLSU_REQ:  if (data_gnt_i)    state_d = VLSU_RESP;
         VLSU_RESP: if (data_rvalid_i) state_d = last ? VLSU_DONE : VLSU_REQ;
         VLSU_DONE: state_d = VLSU_IDLE;
         default:   state_d = VLSU_IDLE;
      endcase
   end

   // Operation type and the one-cycle misalignment pulse.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         is_load_q <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         error_q <= accept && (vl_clamped != 5'd0) && bad_align;
         if (accept) is_load_q <= vlsu_load_i;
      end
   end

   // Strided-load pack word: collects bytes until a register write flushes it.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset)                                 pack_q <= '0;
      else if (accept)                              pack_q <= '0;
      else if (advance && is_load_q && ag_strided)  pack_q <= vr_we_o ? '0 : pack_nxt;
   end

   // Memory request and register-file write outputs, decoded from the current state.
   always_comb begin
      data_req_o   = 1'b0;
      data_addr_o  = '0;
      data_we_o    = 1'b0;
      data_be_o    = '0;
      data_wdata_o = '0;
      vr_offset_o  = '0;
      vr_wdata_o   = '0;
      vr_wbe_o     = '0;
      vr_we_o      = 1'b0;
      pack_nxt     = pack_q;
      pack_nxt[{elem, 3'b000} +: 8] = rd_byte;

      if (state_q == VLSU_REQ) begin
         data_req_o  = 1'b1;
         data_addr_o = cur_addr;
         data_we_o   = !is_load_q;
         data_be_o   = ag_strided ? vlsu_onehot(lane) : unit_mask;
         vr_offset_o = offset;
         if (!is_load_q) data_wdata_o = ag_strided ? {4{st_byte}} : vr_rdata_i;
      end

      if (state_q == VLSU_RESP) begin
         vr_offset_o = offset;
         if (data_rvalid_i && is_load_q) begin
            if (!ag_strided) begin
               vr_we_o    = 1'b1;
               vr_wdata_o = data_rdata_i;
               vr_wbe_o   = unit_mask;
            end else if (elem == 2'd3 || last) begin
               vr_we_o    = 1'b1;
               vr_wdata_o = pack_nxt;
               vr_wbe_o   = packed_mask;
            end
         end
      end
   end

   assign vlsu_ready_o = (state_q == VLSU_IDLE);
   assign vlsu_done_o  = (state_q == VLSU_DONE);
   assign vlsu_error_o = error_q;

endmodule
